// File: rtl/cdbus_tx_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cdbus_tx_sched                                                  |
// | Purpose  : Half-duplex RS485 bus-access scheduler in front of the UART     |
// |            serializer. Waits for the bus to be idle, then sequences tx_en  |
// |            around one frame: pre-drive, grant, post-drive. Owns the        |
// |            tx/tx_en pins; the serializer only supplies bits while granted. |
// | Ports    : clk_i     - system clock                                        |
// |            reset_n   - asynchronous active-low reset                       |
// |            bit_div   - clocks per bit (0 treated as 1)                     |
// |            rx        - raw bus receive line (synchronized inside)          |
// |            tx_req    - requester has a frame, held until tx_done           |
// |            tx_bit    - serializer line output, used while granted          |
// |            tx_done   - 1-clock pulse, serializer finished its frame        |
// |            tx_grant  - serializer may run                                  |
// |            tx/tx_en  - bus driver data / enable                            |
// |            bus_idle  - rx has been high for IDLE_BITS bit-times            |
// |            collision - 1-clock pulse on detected collision                 |
// | Config   : `define CDBUS_COLLISION_EN adds echo compare and back-off state;|
// |            without it collision is tied low.                               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module cdbus_tx_sched #(
  parameter int DIV_W        = 16,
  parameter int IDLE_BITS    = 10,
  parameter int PRE_CLKS     = 4,
  parameter int POST_CLKS    = 4,
  parameter int BACKOFF_BITS = 20
) (
  input  logic             clk_i,
  input  logic             reset_n,
  input  logic [DIV_W-1:0] bit_div,
  input  logic             rx,
  input  logic             tx_req,
  input  logic             tx_bit,
  input  logic             tx_done,
  output logic             tx_grant,
  output logic             tx,
  output logic             tx_en,
  output logic             bus_idle,
  output logic             collision
);

  localparam int               CNT_W    = DIV_W + 8;
  localparam logic [7:0]       IDLE_N   = 8'(IDLE_BITS);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PRE_CLKS - 1);
  localparam logic [CNT_W-1:0] POST_N   = CNT_W'(POST_CLKS);

`ifdef CDBUS_COLLISION_EN
  typedef enum logic [2:0] {
    S_WAIT = 3'd0, S_PRE = 3'd1, S_TX = 3'd2, S_POST = 3'd3, S_BACK = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    S_WAIT = 2'd0, S_PRE = 2'd1, S_TX = 2'd2, S_POST = 2'd3
  } state_t;
`endif

  state_t           state_q, state_d;
  logic             rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d;
  logic [DIV_W-1:0] div_q, div_d, presc_q, presc_d;
  logic [7:0]       bcnt_q, bcnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_idle_q, bus_idle_d;
  logic             tx_q, tx_d, tx_en_q, tx_en_d, grant_q, grant_d;

  // bit_div is live while waiting and frozen once we leave S_WAIT
  logic [DIV_W-1:0] div_eff, div_last;
  assign div_eff  = (state_q == S_WAIT) ? bit_div : div_q;
  assign div_last = (div_eff == '0) ? '0 : div_eff - DIV_W'(1);

`ifdef CDBUS_COLLISION_EN
  logic             collision_q, collision_d;
  logic             txd1_q, txd1_d, txd2_q, txd2_d, mis_q, mis_d;
  logic [DIV_W-1:0] div_one;
  logic [CNT_W-1:0] bo_last;
  assign div_one = (div_q == '0) ? DIV_W'(1) : div_q;
  assign bo_last = CNT_W'(BACKOFF_BITS) * {8'd0, div_one} - CNT_W'(1);
  assign collision = collision_q;
`else
  assign collision = 1'b0;
`endif

  always_comb begin
    rx_meta_d  = rx;
    rx_sync_d  = rx_meta_q;
    div_d      = (state_q == S_WAIT) ? bit_div : div_q;
    presc_d    = presc_q;
    bcnt_d     = bcnt_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    tx_d       = tx_q;
    tx_en_d    = tx_en_q;
    grant_d    = grant_q;
`ifdef CDBUS_COLLISION_EN
    collision_d = 1'b0;
    txd1_d      = tx_q;
    txd2_d      = txd1_q;
    mis_d       = 1'b0;
`endif

    // Idle detector; our own drive never counts as idle time
    if (!rx_sync_q || tx_en_q) begin
      presc_d = '0;
      bcnt_d  = '0;
    end else if (bcnt_q != IDLE_N) begin
      if (presc_q >= div_last) begin
        presc_d = '0;
        bcnt_d  = bcnt_q + 8'd1;
      end else begin
        presc_d = presc_q + DIV_W'(1);
      end
    end
    bus_idle_d = (bcnt_d == IDLE_N);

    case (state_q)
      S_WAIT: begin
        tx_d    = 1'b1;
        tx_en_d = 1'b0;
        grant_d = 1'b0;
        if (tx_req && bus_idle_q) begin
          state_d = S_PRE;
          tx_en_d = 1'b1;
          cnt_d   = '0;
        end
      end
      S_PRE: begin
        // requester withdrawal still releases the bus through post-drive
        if (!tx_req) begin
          state_d = S_POST;
          cnt_d   = '0;
        end else if (cnt_q == PRE_LAST) begin
          state_d = S_TX;
          grant_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_TX: begin
        tx_d = tx_bit;
`ifdef CDBUS_COLLISION_EN
        // rx_sync lags tx by the two synchronizer stages
        if (rx_sync_q != txd2_q) mis_d = 1'b1;
        if (mis_q && (rx_sync_q != txd2_q)) begin
          collision_d = 1'b1;
          grant_d     = 1'b0;
          tx_en_d     = 1'b0;
          tx_d        = 1'b1;
          state_d     = S_BACK;
          cnt_d       = '0;
          mis_d       = 1'b0;
        end else if (tx_done) begin
          state_d = S_POST;
          grant_d = 1'b0;
          tx_d    = 1'b1;
          cnt_d   = '0;
        end
`else
        if (tx_done) begin
          state_d = S_POST;
          grant_d = 1'b0;
          tx_d    = 1'b1;
          cnt_d   = '0;
        end
`endif
      end
      S_POST: begin
        tx_d = 1'b1;
        if (cnt_q == POST_N) begin
          state_d = S_WAIT;
          tx_en_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef CDBUS_COLLISION_EN
      S_BACK: begin
        tx_d    = 1'b1;
        tx_en_d = 1'b0;
        if (!rx_sync_q) begin
          cnt_d = '0;
        end else if (cnt_q >= bo_last) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      default: begin
        state_d = S_WAIT;
        tx_d    = 1'b1;
        tx_en_d = 1'b0;
        grant_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_WAIT;
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      div_q      <= '0;
      presc_q    <= '0;
      bcnt_q     <= '0;
      cnt_q      <= '0;
      bus_idle_q <= 1'b0;
      tx_q       <= 1'b1;
      tx_en_q    <= 1'b0;
      grant_q    <= 1'b0;
`ifdef CDBUS_COLLISION_EN
      collision_q <= 1'b0;
      txd1_q      <= 1'b1;
      txd2_q      <= 1'b1;
      mis_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rx_meta_q  <= rx_meta_d;
      rx_sync_q  <= rx_sync_d;
      div_q      <= div_d;
      presc_q    <= presc_d;
      bcnt_q     <= bcnt_d;
      cnt_q      <= cnt_d;
      bus_idle_q <= bus_idle_d;
      tx_q       <= tx_d;
      tx_en_q    <= tx_en_d;
      grant_q    <= grant_d;
`ifdef CDBUS_COLLISION_EN
      collision_q <= collision_d;
      txd1_q      <= txd1_d;
      txd2_q      <= txd2_d;
      mis_q       <= mis_d;
`endif
    end
  end

  assign tx_grant = grant_q;
  assign tx       = tx_q;
  assign tx_en    = tx_en_q;
  assign bus_idle = bus_idle_q;

endmodule
`default_nettype wire
